// File: rtl/muldiv_pkg.sv
// Shared encodings and defaults for the iterative multiply/divide unit.
package muldiv_pkg;

    localparam int unsigned DEFAULT_WIDTH = 16;

    typedef enum logic [1:0] {
        OP_MULLO = 2'd0,
        OP_MULHI = 2'd1,
        OP_DIVQ  = 2'd2,
        OP_DIVR  = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative unsigned multiply / restoring divide, one bit per clock, sharing
// a single accumulator/shift register pair between both operation kinds.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             div_zero
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_e             state_q, state_d;
    op_e                op_q, op_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   sh_q, sh_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               div_zero_q, div_zero_d;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     rem_try;
    logic [WIDTH:0]     rem_sub;
    logic               rem_ge;
    logic               is_div;

    assign is_div  = (op_q == OP_DIVQ) || (op_q == OP_DIVR);
    assign mul_sum = {1'b0, acc_q} + (sh_q[0] ? {1'b0, b_q} : '0);
    assign rem_try = {acc_q, sh_q[WIDTH-1]};
    assign rem_ge  = (rem_try >= {1'b0, b_q});
    assign rem_sub = rem_try - {1'b0, b_q};

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        cnt_d      = cnt_q;
        b_d        = b_q;
        acc_d      = acc_q;
        sh_d       = sh_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        result_d   = result_q;
        div_zero_d = div_zero_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (start) begin
                    state_d = ST_RUN;
                    op_d    = op_e'(op);
                    b_d     = b;
                    acc_d   = '0;
                    sh_d    = a;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            ST_RUN: begin
                // Multiply shifts right with the product high half in acc;
                // divide shifts left, quotient bits entering sh from the LSB.
                if (is_div) begin
                    acc_d = rem_ge ? rem_sub[WIDTH-1:0] : rem_try[WIDTH-1:0];
                    sh_d  = {sh_q[WIDTH-2:0], rem_ge};
                end else begin
                    acc_d = mul_sum[WIDTH:1];
                    sh_d  = {mul_sum[0], sh_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d    = ST_DONE;
                    busy_d     = 1'b0;
                    done_d     = 1'b1;
                    div_zero_d = is_div && (b_q == '0);
                    case (op_q)
                        OP_MULLO: result_d = sh_d;
                        OP_MULHI: result_d = acc_d;
                        OP_DIVQ:  result_d = sh_d;
                        default:  result_d = acc_d;
                    endcase
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            op_q       <= OP_MULLO;
            cnt_q      <= '0;
            b_q        <= '0;
            acc_q      <= '0;
            sh_q       <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            result_q   <= '0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            cnt_q      <= cnt_d;
            b_q        <= b_d;
            acc_q      <= acc_d;
            sh_q       <= sh_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            result_q   <= result_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign result   = result_q;
    assign div_zero = div_zero_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed cases plus random operations
// compared against a plain-arithmetic reference model.
module tb_muldiv_unit;

    localparam int unsigned W = 16;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [1:0]    op;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          busy;
    logic          done;
    logic [W-1:0]  result;
    logic          div_zero;

    int unsigned tests_run;
    int unsigned tests_failed;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .div_zero (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: {div_zero, result} from plain integer arithmetic.
    function automatic logic [W:0] model(input logic [1:0] mop, input logic [W-1:0] ma,
                                         input logic [W-1:0] mb);
        logic [2*W-1:0] prod;
        prod = {{W{1'b0}}, ma} * {{W{1'b0}}, mb};
        case (mop)
            2'd0:    return {1'b0, prod[W-1:0]};
            2'd1:    return {1'b0, prod[2*W-1:W]};
            2'd2:    return (mb == 0) ? {1'b1, {W{1'b1}}} : {1'b0, ma / mb};
            default: return (mb == 0) ? {1'b1, ma} : {1'b0, ma % mb};
        endcase
    endfunction

    // Called #1 after a rising edge; start is sampled on the next edge.
    task automatic issue(input logic [1:0] iop, input logic [W-1:0] ia, input logic [W-1:0] ib);
        start = 1'b1;
        op    = iop;
        a     = ia;
        b     = ib;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Waits for done after issue(); checks latency, busy width and result.
    task automatic finish_op(input string tag, input logic [1:0] iop, input logic [W-1:0] ia,
                             input logic [W-1:0] ib, input bit disturb);
        int unsigned edges;
        int unsigned busy_cycles;
        logic [W:0]  exp;
        exp         = model(iop, ia, ib);
        edges       = 0;
        busy_cycles = 0;
        if (busy) busy_cycles++;
        while (!done && edges < 100) begin
            if (disturb) begin
                start = 1'b1;
                op    = 2'($urandom);
                a     = W'($urandom);
                b     = W'($urandom);
            end
            @(posedge clk);
            #1;
            edges++;
            if (busy) busy_cycles++;
        end
        start = 1'b0;
        check({tag, "_latency"}, edges, W);
        check({tag, "_busy_cycles"}, busy_cycles, W);
        check({tag, "_result"}, {16'd0, result}, {16'd0, exp[W-1:0]});
        check({tag, "_div_zero"}, {31'd0, div_zero}, {31'd0, exp[W]});
    endtask

    task automatic run_op(input string tag, input logic [1:0] iop, input logic [W-1:0] ia,
                          input logic [W-1:0] ib);
        issue(iop, ia, ib);
        finish_op(tag, iop, ia, ib, 1'b0);
        @(posedge clk);
        #1;
        check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        logic [1:0]   rop;
        logic [W-1:0] ra, rb;
        tests_run    = 0;
        tests_failed = 0;
        rst_n = 1'b0;
        start = 1'b1;
        op    = 2'd0;
        a     = W'(5);
        b     = W'(5);
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_result", {16'd0, result}, 32'd0);
        check("reset_div_zero", {31'd0, div_zero}, 32'd0);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_op("mullo_300x500", 2'd0, W'(300), W'(500));
        check("mullo_const", {16'd0, result}, 32'h49F0);
        run_op("mulhi_300x500", 2'd1, W'(300), W'(500));
        check("mulhi_const", {16'd0, result}, 32'h0002);
        run_op("divq_1000_7", 2'd2, W'(1000), W'(7));
        check("divq_const", {16'd0, result}, 32'h008E);
        run_op("divr_1000_7", 2'd3, W'(1000), W'(7));
        check("divr_const", {16'd0, result}, 32'h0006);
        run_op("divq_by0", 2'd2, W'('h1234), W'(0));
        check("divq_by0_const", {16'd0, result}, 32'hFFFF);
        run_op("divr_by0", 2'd3, W'('h1234), W'(0));
        check("divr_by0_const", {16'd0, result}, 32'h1234);

        // Start re-pulsed and operands changed throughout RUN.
        issue(2'd1, W'('hFFFF), W'('hFFFF));
        finish_op("mulhi_disturb", 2'd1, W'('hFFFF), W'('hFFFF), 1'b1);
        check("mulhi_disturb_const", {16'd0, result}, 32'hFFFE);
        @(posedge clk);
        #1;
        check("mulhi_disturb_single_done", {31'd0, done}, 32'd0);
        check("mulhi_disturb_idle", {31'd0, busy}, 32'd0);

        // Asynchronous reset during the 8th iteration of a divide.
        issue(2'd2, W'(50000), W'(3));
        repeat (7) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_busy", {31'd0, busy}, 32'd0);
        check("async_rst_done", {31'd0, done}, 32'd0);
        check("async_rst_result", {16'd0, result}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_op("mullo_3x4", 2'd0, W'(3), W'(4));
        check("mullo_3x4_const", {16'd0, result}, 32'h000C);

        // Back-to-back: second start in the DONE cycle.
        issue(2'd0, W'(2), W'(2));
        finish_op("b2b_first", 2'd0, W'(2), W'(2), 1'b0);
        check("b2b_first_const", {16'd0, result}, 32'h0004);
        issue(2'd2, W'(9), W'(3));
        check("b2b_no_idle_busy", {31'd0, busy}, 32'd1);
        check("b2b_no_idle_done", {31'd0, done}, 32'd0);
        finish_op("b2b_second", 2'd2, W'(9), W'(3), 1'b0);
        check("b2b_second_const", {16'd0, result}, 32'h0003);
        @(posedge clk);
        #1;

        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom);
            ra  = W'($urandom);
            rb  = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
            if ($urandom_range(0, 3) == 0) rb = W'($urandom_range(1, 20));
            run_op($sformatf("rand%0d_op%0d", i, rop), rop, ra, rb);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand and result width.
REQ-002 SHALL have port clk  input  1  rising-edge clock, the only clock.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  request a new operation; sampled on rising clk.
REQ-005 SHALL have port op  input  2  operation: 0 MULLO, 1 MULHI, 2 DIVQ, 3 DIVR.
REQ-006 SHALL have port a  input  WIDTH  multiplicand or dividend (the res value).
REQ-007 SHALL have port b  input  WIDTH  multiplier or divisor (the selected register value).
REQ-008 SHALL have port busy  output  1  operation in progress.
REQ-009 SHALL have port done  output  1  one-cycle pulse; result valid.
REQ-010 SHALL have port result  output  WIDTH  result, forwarded to the register file write_data.
REQ-011 SHALL have port div_zero  output  1  last division had b==0.

Function
REQ-012 SHALL implement three states: IDLE, RUN and DONE.
REQ-013 SHALL accept start only in IDLE or DONE; it latches a, b and op into internal registers, clears the iteration count, and moves to RUN.
REQ-014 SHALL ignore start while in RUN, with no effect on the operation or its outputs.
REQ-015 SHALL ignore changes on a, b and op after acceptance.
REQ-016 SHALL perform exactly one iteration per clock in RUN, WIDTH iterations total; the state moves to DONE on the edge completing iteration WIDTH.
REQ-017 SHALL drive busy high from the edge accepting start until the edge entering DONE: exactly WIDTH cycles.
REQ-018 SHALL drive done high only while in DONE, for exactly one cycle.
REQ-019 SHALL make result and div_zero update on the edge entering DONE and hold them until the next DONE entry or reset.
REQ-020 SHALL move from DONE to IDLE on the next edge, unless start is accepted on that edge, in which case the state moves to RUN.
REQ-021 SHALL perform multiplication as unsigned shift-add into a 2*WIDTH product; MULLO returns bits [WIDTH-1:0] and MULHI returns bits [2*WIDTH-1:WIDTH].
REQ-022 SHALL perform division as unsigned restoring division producing one quotient bit per iteration; DIVQ returns the quotient and DIVR the remainder.
REQ-023 SHALL keep full latency when b==0 in division, returning quotient all-ones and remainder a, with div_zero=1.
REQ-024 SHALL set div_zero=0 on completion of every multiplication and of every division with b!=0.
REQ-025 SHALL have latency from the start-sampling edge E0 to done high of WIDTH edges; done is high in the cycle following edge E0+WIDTH.

Reset
REQ-026 SHALL, on rst_n low at any time including mid-RUN, immediately set state=IDLE, busy=0, done=0, result=0, div_zero=0, counter=0, and latched operands=0; the in-flight operation is discarded.
REQ-027 SHALL accept no start while rst_n is low; the first start SHALL be accepted on the first rising clk with rst_n high.

Structure
REQ-028 SHALL place the op encodings (MULLO, MULHI, DIVQ, DIVR), the state encoding (IDLE, RUN, DONE) and the default WIDTH in the shared package muldiv_pkg.
REQ-029 SHALL implement the block as a single module with no sub-module; one shared accumulator/shift register pair serves both multiply and divide.

Verification
REQ-030 SHALL cover: MULLO a=300, b=500 -> result 0x49F0, then MULHI same operands -> 0x0002; div_zero=0 for both.
REQ-031 SHALL cover: DIVQ a=1000, b=7 -> 0x008E; DIVR a=1000, b=7 -> 0x0006.
REQ-032 SHALL cover: DIVQ a=0x1234, b=0 -> 0xFFFF, div_zero=1; DIVR with the same operands -> 0x1234, div_zero=1; done still arrives after 16 cycles.
REQ-033 SHALL cover: MULHI a=0xFFFF, b=0xFFFF with start re-pulsed and a/b changed during RUN -> 0xFFFE, busy high exactly 16 cycles, done pulses exactly once.
REQ-034 SHALL cover: rst_n low during the 8th iteration of a DIVQ -> busy, done and result all 0 without waiting for clk; after release, MULLO 3*4 -> 0x000C in 16 cycles.
REQ-035 SHALL cover: start asserted in the DONE cycle (MULLO 2*2, then DIVQ 9/3) -> second operation accepted with no IDLE cycle; results 0x0004 then 0x0003.
